// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
//   Owns the program counter and issues instruction-memory reads with a
//   req/ack handshake. Returned words go into a 2-entry FIFO whose head is
//   presented to decode. Redirects flush the FIFO and the in-flight fetch.
//   Memory stalls and misaligned redirect targets are flagged as sticky errors.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall_in       decode back-pressure (pop = fetch_valid & ~stall_in)
//   redirect_valid one-cycle redirect pulse
//   redirect_pc    redirect target (bits [1:0] are dropped)
//   imem_req       read request, held until imem_ack
//   imem_addr      read address, stable while imem_req = 1
//   imem_ack       read completes this cycle
//   imem_rdata     instruction word, sampled with imem_ack
//   fetch_valid    FIFO head valid
//   fetch_instr    FIFO head instruction
//   fetch_pc       FIFO head PC
//   err_timeout    sticky: a request waited TIMEOUT cycles
//   err_misalign   sticky: a redirect target had nonzero bits [1:0]
module fetch_ctrl #(
  parameter int unsigned       DATA_W   = 33,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [DATA_W-1:0] fetch_pc,
  output logic              err_timeout,
  output logic              err_misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] q_instr_q [2];
  logic [DATA_W-1:0] q_instr_d [2];
  logic [DATA_W-1:0] q_pc_q [2];
  logic [DATA_W-1:0] q_pc_d [2];
  logic [7:0]        wait_q, wait_d;
  logic              err_to_q, err_to_d;
  logic              err_mis_q, err_mis_d;

  logic              pop;
  logic              push;
  logic              busy_after;
  logic [1:0]        wr_idx;

  // Handshake qualifiers for this cycle
  always_comb begin
    pop        = (count_q != 2'd0) && !stall_in && !redirect_valid;
    push       = (state_q == REQ) && imem_ack && !redirect_valid;
    // A request still outstanding after this edge (no ack yet)
    busy_after = (state_q != IDLE) && !imem_ack;
  end

  // Next-state: PC, FIFO occupancy, request issue
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    count_d = count_q;

    if (redirect_valid) begin
      pc_d = {redirect_pc[DATA_W-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + DATA_W'(4);
    end

    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q - 2'(pop) + 2'(push);
    end

    // An ack always has room because a request is only issued when the
    // FIFO will hold at most one entry after this cycle.
    if (busy_after) begin
      state_d = redirect_valid ? DRAIN : state_q;
    end else if (count_d <= 2'd1) begin
      state_d = REQ;
      addr_d  = pc_d;
    end else begin
      state_d = IDLE;
    end
  end

  // FIFO storage: slot 0 is the head; a pop shifts slot 1 down
  always_comb begin
    q_instr_d = q_instr_q;
    q_pc_d    = q_pc_q;
    wr_idx    = count_q - 2'(pop);
    if (!redirect_valid) begin
      if (pop) begin
        q_instr_d[0] = q_instr_q[1];
        q_pc_d[0]    = q_pc_q[1];
      end
      if (push) begin
        if (wr_idx[0]) begin
          q_instr_d[1] = imem_rdata;
          q_pc_d[1]    = addr_q;
        end else begin
          q_instr_d[0] = imem_rdata;
          q_pc_d[0]    = addr_q;
        end
      end
    end
  end

  // Wait counter and sticky error flags
  always_comb begin
    wait_d    = wait_q;
    err_to_d  = err_to_q;
    err_mis_d = err_mis_q | (redirect_valid & (|redirect_pc[1:0]));
    if (state_q != IDLE) begin
      if (imem_ack) begin
        wait_d = 8'd0;
      end else begin
        wait_d = sat_inc8(wait_q);
        if (wait_d >= TIMEOUT_CNT) begin
          err_to_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      count_q      <= 2'd0;
      q_instr_q[0] <= '0;
      q_instr_q[1] <= '0;
      q_pc_q[0]    <= '0;
      q_pc_q[1]    <= '0;
      wait_q       <= 8'd0;
      err_to_q     <= 1'b0;
      err_mis_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      q_instr_q[0] <= q_instr_d[0];
      q_instr_q[1] <= q_instr_d[1];
      q_pc_q[0]    <= q_pc_d[0];
      q_pc_q[1]    <= q_pc_d[1];
      wait_q       <= wait_d;
      err_to_q     <= err_to_d;
      err_mis_q    <= err_mis_d;
    end
  end

  assign imem_req     = (state_q != IDLE);
  assign imem_addr    = addr_q;
  assign fetch_valid  = (count_q != 2'd0);
  assign fetch_instr  = q_instr_q[0];
  assign fetch_pc     = q_pc_q[0];
  assign err_timeout  = err_to_q;
  assign err_misalign = err_mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl. A memory responder drives random ack
// delays; a reference model tracks the expected fetch stream as a queue of
// (pc, instr) pairs and is checked by a monitor at every rising edge.
module tb_fetch_ctrl;
  localparam int W = 33;
  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall_in = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack = 1'b0;
  logic [W-1:0] imem_rdata = '0;
  logic         fetch_valid;
  logic [W-1:0] fetch_instr;
  logic [W-1:0] fetch_pc;
  logic         err_timeout;
  logic         err_misalign;

  fetch_ctrl #(.DATA_W(W), .RESET_PC('0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .err_timeout(err_timeout), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] mem_word(logic [W-1:0] a);
    return {a[0], a[W-1:1]} ^ 33'h0_DEAD_BEEF;
  endfunction

  // ---------------- reference model + monitor ----------------
  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } ent_t;

  ent_t         expq[$];
  logic [W-1:0] exp_pc;
  logic [W-1:0] cur_req_addr;
  bit           exp_req, prev_held, discard, exp_mis, exp_to;
  int           wcnt;

  always @(posedge clk) begin
    bit held_n;
    if (!reset) begin
      expq.delete();
      exp_pc = '0; cur_req_addr = '0;
      exp_req = 0; prev_held = 0; discard = 0;
      exp_mis = 0; exp_to = 0; wcnt = 0;
    end else begin
      // compare what the DUT shows now against the model state
      chk("fetch_valid", W'(fetch_valid), W'(expq.size() != 0));
      if (expq.size() != 0) begin
        chk("fetch_pc", fetch_pc, expq[0].pc);
        chk("fetch_instr", fetch_instr, expq[0].instr);
      end
      chk("imem_req", W'(imem_req), W'(exp_req));
      if (imem_req) begin
        if (!prev_held) cur_req_addr = exp_pc;
        chk("imem_addr", imem_addr, cur_req_addr);
      end
      chk("err_misalign", W'(err_misalign), W'(exp_mis));
      chk("err_timeout", W'(err_timeout), W'(exp_to));

      // advance the model with this cycle's inputs
      held_n = imem_req && !imem_ack;
      if (redirect_valid) begin
        expq.delete();
        exp_pc = {redirect_pc[W-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) exp_mis = 1;
        discard = held_n;
      end else begin
        if (fetch_valid && !stall_in && expq.size() != 0) void'(expq.pop_front());
        if (imem_req && imem_ack) begin
          if (discard) discard = 0;
          else begin
            expq.push_back('{pc: cur_req_addr, instr: mem_word(cur_req_addr)});
            exp_pc = exp_pc + W'(4);
          end
        end
      end
      if (imem_req && !imem_ack) wcnt++;
      else if (imem_req && imem_ack) wcnt = 0;
      if (wcnt >= TIMEOUT) exp_to = 1;
      exp_req   = held_n || (expq.size() <= 1);
      prev_held = held_n;
    end
  end

  // ---------------- memory responder + stimulus ----------------
  bit mem_busy = 0;
  int dly = 0;
  int force_dly = -1;
  int max_dly = 0;

  task automatic cycle(input bit st, input bit rv, input logic [W-1:0] rpc);
    @(negedge clk);
    if (imem_ack) mem_busy = 0;
    imem_ack = 1'b0;
    imem_rdata = {1'b0, $urandom};
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        dly = (force_dly >= 0) ? force_dly : $urandom_range(0, max_dly);
      end
      if (dly == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        dly--;
      end
    end
    stall_in = st;
    redirect_valid = rv;
    redirect_pc = rpc;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_req"}, W'(imem_req), '0);
    chk({tag, "_addr"}, imem_addr, '0);
    chk({tag, "_fvalid"}, W'(fetch_valid), '0);
    chk({tag, "_finstr"}, fetch_instr, '0);
    chk({tag, "_fpc"}, fetch_pc, '0);
    chk({tag, "_errto"}, W'(err_timeout), '0);
    chk({tag, "_errmis"}, W'(err_misalign), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           rv;
    logic [W-1:0] rpc;
    int           guard;

    #12;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // continuous stream, single-cycle memory
    force_dly = 0;
    for (int i = 0; i < 40; i++) cycle(0, 0, '0);

    // decode stall for 6 cycles, then resume
    for (int i = 0; i < 6; i++) cycle(1, 0, '0);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0);

    // redirect to 0x100 while a request waits for a slow ack
    force_dly = 3;
    guard = 0;
    do begin
      cycle(0, 0, '0);
      guard++;
    end while (!(imem_req && !imem_ack && dly >= 2) && guard < 50);
    chk("drain_setup", W'(guard < 50), W'(1));
    cycle(0, 1, 33'h100);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0);

    // misaligned redirect coinciding with an ack
    force_dly = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0, '0);
    cycle(0, 1, 33'h103);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0);
    chk("misalign_set", W'(err_misalign), W'(1));

    // timeout at the top of the address space, then wrap to 0
    cycle(0, 1, 33'h1_FFFF_FFFC);
    force_dly = 300;
    for (int i = 0; i < 200; i++) cycle(0, 0, '0);
    chk("timeout_early", W'(err_timeout), W'(0));
    for (int i = 0; i < 110; i++) cycle(0, 0, '0);
    chk("timeout_set", W'(err_timeout), W'(1));
    force_dly = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, '0);
    chk("timeout_sticky", W'(err_timeout), W'(1));

    // randomized traffic
    force_dly = -1;
    max_dly = 3;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) rpc = 33'h1_FFFF_FFF4;
      else rpc = {1'($urandom_range(0, 1)), 32'($urandom)};
      cycle($urandom_range(0, 99) < 30, rv, rpc);
    end

    // asynchronous reset with the queue full
    force_dly = 0;
    for (int i = 0; i < 6; i++) cycle(1, 0, '0);
    chk("full_before_reset", W'(fetch_valid), W'(1));
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    mem_busy = 0;
    imem_ack = 1'b0;
    stall_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) cycle(0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
